dsp_mac_sequencer: RTL and testbench

- Sequences the 18x18 multiply / 48-bit post-add DSP slice as a dot-product (multiply-accumulate) engine.
- Accepts a vector length and a stream of (a, b) operand pairs over a valid/ready handshake.
- Drives the slice's A/B inputs, OPMODE and clock enables, tracking pipeline latency with a tag shift register.
- Captures the final P value and presents it as a one-cycle result strobe. Sits between the stream source and one DSP slice instance.

---
 rtl/dsp_mac_sequencer_if.sv | 28 ++
 rtl/dsp_mac_sequencer.sv | 76 +++++++
 tb/tb_dsp_mac_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream, result and DSP-slice signals of the MAC sequencer
interface dsp_mac_sequencer_if #(parameter int LEN_W = 8);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             abort;
   logic             in_valid;
   logic             in_ready;
   logic [17:0]      a_in;
   logic [17:0]      b_in;
   logic [17:0]      dsp_a;
   logic [17:0]      dsp_b;
   logic [7:0]       dsp_opmode;
   logic             dsp_ce_ab;
   logic             dsp_ce_m;
   logic             dsp_ce_p;
   logic [47:0]      dsp_p;
   logic             busy;
   logic             res_valid;
   logic [47:0]      res_data;
   modport master (
      output start, len, abort, in_valid, a_in, b_in, dsp_p,
      input  in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce_ab, dsp_ce_m, dsp_ce_p, busy, res_valid, res_data
   );
   modport slave (
      input  start, len, abort, in_valid, a_in, b_in, dsp_p,
      output in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce_ab, dsp_ce_m, dsp_ce_p, busy, res_valid, res_data
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one 18x18 DSP slice as a dot-product engine and strobes out the final P
module dsp_mac_sequencer #(
   parameter int LEN_W    = 8,
   parameter int OP_DELAY = 3
) (
   input logic              CLK,
   input logic              RST,
   dsp_mac_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RESULT} state_t;
   state_t                  state, state_nx;
   logic [LEN_W-1:0]        rem;
   logic                    first;
   logic                    empty;
   logic [17:0]             a_q, b_q;
   logic [47:0]             res_q;
   // pipe[0] travels with dsp_a/dsp_b, pipe[OP_DELAY] lines up with the product at the post-adder
   logic [OP_DELAY:0][2:0]  pipe;
   logic [2:0]              t, tag;
   logic                    xfer, flush;
   assign t     = pipe[OP_DELAY];
   assign xfer  = state == LOAD && bus.in_valid && !bus.abort;
   assign flush = (state == LOAD || state == DRAIN) && bus.abort;
   assign tag   = xfer ? {1'b1, first, rem == LEN_W'(1)} : 3'b000;
   // state register
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else     state <= state_nx;
   // next-state logic
   always_comb
      case (state)
         IDLE:    state_nx = bus.start ? (bus.len != '0 ? LOAD : RESULT) : IDLE;
         LOAD:    state_nx = bus.abort ? IDLE : (xfer && rem == LEN_W'(1)) ? DRAIN : LOAD;
         DRAIN:   state_nx = bus.abort ? IDLE : (t[2] && t[0]) ? RESULT : DRAIN;
         default: state_nx = IDLE;
      endcase
   // operand registers, remaining count, tag pipe and held result
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         rem   <= '0;
         first <= 1'b0;
         empty <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         pipe  <= '0;
         res_q <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            rem   <= bus.len;
            first <= 1'b1;
            empty <= bus.len == '0;
         end else if (xfer) begin
            rem   <= rem - LEN_W'(1);
            first <= 1'b0;
         end
         if (xfer) begin
            a_q <= bus.a_in;
            b_q <= bus.b_in;
         end
         pipe <= flush ? '0 : {pipe[OP_DELAY-1:0], tag};
         if (state == RESULT) res_q <= bus.res_data;
      end
   // outputs; res_data shows the live P during the strobe so data and strobe coincide
   always_comb begin
      bus.in_ready   = state == LOAD;
      bus.busy       = state != IDLE;
      bus.res_valid  = state == RESULT;
      bus.res_data   = state == RESULT ? (empty ? '0 : bus.dsp_p) : res_q;
      bus.dsp_a      = a_q;
      bus.dsp_b      = b_q;
      bus.dsp_ce_ab  = state != IDLE && !empty;
      bus.dsp_ce_m   = state != IDLE && !empty;
      bus.dsp_ce_p   = t[2];
      bus.dsp_opmode = t[2] ? (t[1] ? 8'h01 : 8'h09) : 8'h08;
   end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed vectors against a behavioural DSP slice with hand-computed results
module tb_dsp_mac_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dsp_mac_sequencer_if bus();
   dsp_mac_sequencer dut (.CLK(clk), .RST(rst), .bus(bus));
   int          n_cmp = 0, n_bad = 0, cyc = 0, rv_cnt = 0, rv_cyc = 0, xfer_cyc = 0, n0 = 0;
   logic [47:0] rv_data = '0;
   logic [7:0]  opq[$];
   bit          ce_seen = 1'b0;
   logic signed [17:0] a0, b0, a1, b1;
   logic signed [35:0] m;
   logic signed [47:0] p;
   assign bus.dsp_p = p;
   // slice model: A0/B0, A1/B1, M stages then P register
   always @(posedge clk) begin
      if (bus.dsp_ce_ab) begin
         a0 <= bus.dsp_a;
         b0 <= bus.dsp_b;
         a1 <= a0;
         b1 <= b0;
      end
      if (bus.dsp_ce_m) m <= a1 * b1;
      if (bus.dsp_ce_p) p <= (bus.dsp_opmode == 8'h01) ? {{12{m[35]}}, m} : p + {{12{m[35]}}, m};
   end
   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;
   // monitor of result strobes, P enables and any DSP enable
   always @(negedge clk) begin
      if (bus.res_valid) begin
         rv_cnt++;
         rv_cyc  = cyc;
         rv_data = bus.res_data;
      end
      if (bus.dsp_ce_p) opq.push_back(bus.dsp_opmode);
      if (bus.dsp_ce_ab || bus.dsp_ce_m || bus.dsp_ce_p) ce_seen = 1'b1;
   end
   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic start_op(input logic [7:0] l);
      bus.start = 1'b1;
      bus.len   = l;
      step();
      bus.start = 1'b0;
   endtask
   task automatic send(input logic [17:0] a, input logic [17:0] b);
      int k = 0;
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      bus.b_in     = b;
      while (!bus.in_ready && k < 20) begin
         step();
         k++;
      end
      chk("send_ready", 48'(bus.in_ready), 48'd1);
      xfer_cyc = cyc;
      step();
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_res(input int base);
      int k = 0;
      while (rv_cnt == base && k < 30) begin
         step();
         k++;
      end
      chk("res_seen", 48'(rv_cnt != base), 48'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
      repeat (3) step();
      chk("rst_ready", 48'(bus.in_ready), 48'd0);
      chk("rst_busy", 48'(bus.busy), 48'd0);
      chk("rst_rv", 48'(bus.res_valid), 48'd0);
      chk("rst_data", bus.res_data, 48'd0);
      chk("rst_opmode", 48'(bus.dsp_opmode), 48'h08);
      chk("rst_ce", 48'({bus.dsp_ce_ab, bus.dsp_ce_m, bus.dsp_ce_p}), 48'd0);
      chk("rst_dsp_a", 48'(bus.dsp_a), 48'd0);
      rst = 1'b0;
      step();
      // basic: 2*3 + 4*5 + (-1)*7 = 19
      n0 = rv_cnt; opq.delete();
      start_op(8'd3);
      send(18'sd2, 18'sd3);
      send(18'sd4, 18'sd5);
      send(-18'sd1, 18'sd7);
      chk("basic_drain_ready", 48'(bus.in_ready), 48'd0);
      wait_res(n0);
      chk("basic_latency", 48'(rv_cyc - xfer_cyc), 48'd5);
      chk("basic_data", rv_data, 48'd19);
      repeat (3) step();
      chk("basic_once", 48'(rv_cnt - n0), 48'd1);
      chk("basic_nops", 48'(opq.size()), 48'd3);
      chk("basic_op0", 48'(opq[0]), 48'h01);
      chk("basic_op1", 48'(opq[1]), 48'h09);
      chk("basic_op2", 48'(opq[2]), 48'h09);
      chk("basic_hold", bus.res_data, 48'd19);
      chk("basic_idle", 48'(bus.busy), 48'd0);
      // bubbles: 10*10 + 1*(-1) = 99
      n0 = rv_cnt; opq.delete();
      start_op(8'd2);
      send(18'sd10, 18'sd10);
      repeat (4) step();
      chk("bub_ready", 48'(bus.in_ready), 48'd1);
      send(18'sd1, -18'sd1);
      wait_res(n0);
      chk("bub_data", rv_data, 48'd99);
      repeat (3) step();
      chk("bub_once", 48'(rv_cnt - n0), 48'd1);
      chk("bub_nops", 48'(opq.size()), 48'd2);
      chk("bub_op0", 48'(opq[0]), 48'h01);
      chk("bub_op1", 48'(opq[1]), 48'h09);
      // abort after two transfers, with a pending pair in the abort cycle
      n0 = rv_cnt; opq.delete();
      start_op(8'd4);
      send(18'sd1, 18'sd2);
      send(18'sd3, 18'sd4);
      bus.abort = 1'b1; bus.in_valid = 1'b1; bus.a_in = 18'sd5; bus.b_in = 18'sd5;
      step();
      bus.abort = 1'b0; bus.in_valid = 1'b0;
      chk("abort_busy", 48'(bus.busy), 48'd0);
      chk("abort_ready", 48'(bus.in_ready), 48'd0);
      repeat (10) step();
      chk("abort_no_res", 48'(rv_cnt - n0), 48'd0);
      chk("abort_no_p", 48'(opq.size()), 48'd0);
      chk("abort_hold", bus.res_data, 48'd99);
      n0 = rv_cnt; opq.delete();
      start_op(8'd1);
      send(18'sd6, 18'sd7);
      wait_res(n0);
      chk("post_abort_data", rv_data, 48'd42);
      chk("post_abort_op0", 48'(opq[0]), 48'h01);
      repeat (3) step();
      // zero length: strobe on the cycle after start is sampled, no DSP enables
      ce_seen = 1'b0; n0 = rv_cnt;
      bus.start = 1'b1; bus.len = 8'd0;
      chk("zero_pre_rv", 48'(bus.res_valid), 48'd0);
      step();
      bus.start = 1'b0;
      chk("zero_rv", 48'(bus.res_valid), 48'd1);
      chk("zero_data", bus.res_data, 48'd0);
      step();
      chk("zero_rv_off", 48'(bus.res_valid), 48'd0);
      chk("zero_busy", 48'(bus.busy), 48'd0);
      chk("zero_no_ce", 48'(ce_seen), 48'd0);
      chk("zero_once", 48'(rv_cnt - n0), 48'd1);
      // asynchronous reset in the middle of DRAIN
      n0 = rv_cnt;
      start_op(8'd2);
      send(18'sd1, 18'sd1);
      send(18'sd2, 18'sd2);
      step();
      chk("ar_busy_pre", 48'(bus.busy), 48'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", 48'(bus.busy), 48'd0);
      chk("ar_ready", 48'(bus.in_ready), 48'd0);
      chk("ar_rv", 48'(bus.res_valid), 48'd0);
      chk("ar_data", bus.res_data, 48'd0);
      chk("ar_opmode", 48'(bus.dsp_opmode), 48'h08);
      chk("ar_ce", 48'({bus.dsp_ce_ab, bus.dsp_ce_m, bus.dsp_ce_p}), 48'd0);
      chk("ar_dsp_a", 48'(bus.dsp_a), 48'd0);
      repeat (2) step();
      rst = 1'b0;
      step();
      start_op(8'd1);
      send(18'sd3, 18'sd3);
      wait_res(n0);
      chk("ar_after_data", rv_data, 48'd9);
      repeat (3) step();
      chk("ar_once", 48'(rv_cnt - n0), 48'd1);
      // width: two (-2^17)^2 products sum to 2^35; start during LOAD ignored
      n0 = rv_cnt;
      start_op(8'd2);
      send(18'sh20000, 18'sh20000);
      bus.start = 1'b1; bus.len = 8'd5;
      send(18'sh20000, 18'sh20000);
      bus.start = 1'b0;
      wait_res(n0);
      chk("wrap_data", rv_data, 48'h0008_0000_0000);
      repeat (4) step();
      chk("wrap_idle", 48'(bus.busy), 48'd0);
      chk("wrap_once", 48'(rv_cnt - n0), 48'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
